// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: sequencing controller for the six cascaded BCD digit counters of an
// HH:MM:SS 24 h clock. Issues one-cycle per-digit enable/load commands from the 1 Hz tick
// and runs the HH/MM time-setting mode machine.
module clock_time_ctrl (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] q_s0,
  input  logic [3:0] q_s1,
  input  logic [3:0] q_m0,
  input  logic [3:0] q_m1,
  input  logic [3:0] q_h0,
  input  logic [3:0] q_h1,
  output logic [5:0] en,
  output logic [5:0] load,
  output logic [3:0] d,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {StRun = 2'd0, StSetH = 2'd1, StSetM = 2'd2} mode_e;

  localparam int unsigned S0 = 0;
  localparam int unsigned S1 = 1;
  localparam int unsigned M0 = 2;
  localparam int unsigned M1 = 3;
  localparam int unsigned H0 = 4;
  localparam int unsigned H1 = 5;

  mode_e      mode_q, mode_d;
  logic [5:0] en_q, en_d;
  logic [5:0] load_q, load_d;
  logic [3:0] d_q, d_d;
  logic       tick_pend_q, tick_pend_d;
  logic       busy_q, busy_d;

  logic [6:0] hour_val, min_val;
  logic       c0, c1, c2, c3;

  // Out-of-range digits compare with >= so they behave as the limit and wrap to 0.
  assign hour_val = {3'b000, q_h1} * 7'd10 + {3'b000, q_h0};
  assign min_val  = {3'b000, q_m1} * 7'd10 + {3'b000, q_m0};
  assign c0 = (q_s0 >= 4'd9);
  assign c1 = c0 && (q_s1 >= 4'd5);
  assign c2 = c1 && (q_m0 >= 4'd9);
  assign c3 = c2 && (q_m1 >= 4'd5);

  // Next command, mode and pending-tick state; events are taken only while not busy.
  always_comb begin
    en_d        = '0;
    load_d      = '0;
    d_d         = '0;
    mode_d      = mode_q;
    tick_pend_d = tick_pend_q;
    unique case (mode_q)
      StRun: begin
        if (busy_q) begin
          if (tick) tick_pend_d = 1'b1;
        end else if (tick || tick_pend_q) begin
          // A fresh tick colliding with a pending one stays pending for the next slot.
          tick_pend_d = tick && tick_pend_q;
          en_d[S0] = 1'b1;
          if (c0) begin
            if (q_s1 >= 4'd5) load_d[S1] = 1'b1;
            else              en_d[S1]   = 1'b1;
          end
          if (c1) en_d[M0] = 1'b1;
          if (c2) begin
            if (q_m1 >= 4'd5) load_d[M1] = 1'b1;
            else              en_d[M1]   = 1'b1;
          end
          if (c3 && (hour_val >= 7'd23)) begin
            load_d[H0] = 1'b1;
            load_d[H1] = 1'b1;
          end else if (c3) begin
            en_d[H0] = 1'b1;
            if (q_h0 >= 4'd9) en_d[H1] = 1'b1;
          end
        end
        if (btn_mode) mode_d = StSetH;
      end
      StSetH: begin
        tick_pend_d = 1'b0;
        if (btn_mode) begin
          mode_d = StSetM;
        end else if (btn_inc && !busy_q) begin
          if (hour_val >= 7'd23) begin
            load_d[H0] = 1'b1;
            load_d[H1] = 1'b1;
          end else if (q_h0 >= 4'd9) begin
            load_d[H0] = 1'b1;
            en_d[H1]   = 1'b1;
          end else begin
            en_d[H0] = 1'b1;
          end
        end
      end
      StSetM: begin
        tick_pend_d = 1'b0;
        if (btn_mode) begin
          // Returning to run restarts seconds at :00.
          mode_d     = StRun;
          load_d[S0] = 1'b1;
          load_d[S1] = 1'b1;
        end else if (btn_inc && !busy_q) begin
          if (min_val >= 7'd59) begin
            load_d[M0] = 1'b1;
            load_d[M1] = 1'b1;
          end else if (q_m0 >= 4'd9) begin
            load_d[M0] = 1'b1;
            en_d[M1]   = 1'b1;
          end else begin
            en_d[M0] = 1'b1;
          end
        end
      end
      default: begin
        mode_d      = StRun;
        tick_pend_d = 1'b0;
      end
    endcase
    busy_d = (en_d != 6'd0) || (load_d != 6'd0);
  end

  // State and registered outputs; clr aborts any command in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mode_q      <= StRun;
      en_q        <= '0;
      load_q      <= '0;
      d_q         <= '0;
      tick_pend_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      en_q        <= en_d;
      load_q      <= load_d;
      d_q         <= d_d;
      tick_pend_q <= tick_pend_d;
      busy_q      <= busy_d;
    end
  end

  assign en   = en_q;
  assign load = load_q;
  assign d    = d_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: behavioural digit counters around the DUT, time kept as
// seconds-of-day, expected commands derived from how each digit must change.
module tb_clock_time_ctrl;

  logic       clk, clr, tick, btn_mode, btn_inc;
  logic [5:0] en, load;
  logic [3:0] d;
  logic [1:0] mode;
  logic [3:0] dig [6];
  logic       pre_en;
  logic [23:0] pre_val;
  logic [23:0] obs_t;

  int errs   = 0;
  int checks = 0;
  int cur_t  = 0;

  clock_time_ctrl u_dut (
    .clk      (clk),
    .clr      (clr),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .q_s0     (dig[0]),
    .q_s1     (dig[1]),
    .q_m0     (dig[2]),
    .q_m1     (dig[3]),
    .q_h0     (dig[4]),
    .q_h1     (dig[5]),
    .en       (en),
    .load     (load),
    .d        (d),
    .mode     (mode)
  );

  assign obs_t = {dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Digit counters: load beats enable, enable wraps 9 -> 0.
  always @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (pre_en)       dig[k] <= pre_val[4*k +: 4];
      else if (load[k]) dig[k] <= d;
      else if (en[k])   dig[k] <= (dig[k] == 4'd9) ? 4'd0 : dig[k] + 4'd1;
    end
  end

  function automatic logic [23:0] pack(input int t);
    int s, m, h;
    s = t % 60;
    m = (t / 60) % 60;
    h = t / 3600;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // {load, en} implied by the digit changes: +1 is an enable, anything else is a load,
  // except a units digit rolling 9 -> 0 under a tick, which is its own enable.
  function automatic logic [11:0] exp_cmd(input int t_old, input int t_new, input bit on_tick);
    logic [23:0] o, n;
    logic [5:0]  e, l;
    logic [3:0]  a, b;
    o = pack(t_old);
    n = pack(t_new);
    e = '0;
    l = '0;
    for (int k = 0; k < 6; k++) begin
      a = o[4*k +: 4];
      b = n[4*k +: 4];
      if (a != b) begin
        if (b == a + 4'd1)                                    e[k] = 1'b1;
        else if (on_tick && a == 4'd9 && b == 4'd0 && k % 2 == 0) e[k] = 1'b1;
        else                                                  l[k] = 1'b1;
      end
    end
    return {l, e};
  endfunction

  function automatic int hour_inc(input int t);
    return (((t / 3600) + 1) % 24) * 3600 + t % 3600;
  endfunction

  function automatic int min_inc(input int t);
    int m;
    m = (t / 60) % 60;
    return t - m * 60 + ((m + 1) % 60) * 60;
  endfunction

  task automatic preset(input int t);
    @(negedge clk);
    pre_val = pack(t);
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    cur_t  = t;
  endtask

  // One-cycle input pulse; returns the command cycle and the cycle after it.
  task automatic pulse(input logic t, input logic m, input logic i,
                       output logic [5:0] e, output logic [5:0] l, output logic [3:0] dv,
                       output logic [5:0] e_after, output logic [5:0] l_after);
    @(negedge clk);
    tick = t; btn_mode = m; btn_inc = i;
    @(negedge clk);
    tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    e = en; l = load; dv = d;
    @(negedge clk);
    e_after = en; l_after = load;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({en, load, d, mode} !== 18'd0) begin
      errs++;
      $display("FAIL reset_outputs: en=%b load=%b d=%h mode=%0d, required all 0", en, load, d, mode);
    end
    clr = 1'b0;
    preset(0);
    checks++;
    if (obs_t !== pack(0)) begin
      errs++;
      $display("FAIL reset_preset: time=%h, required 000000", obs_t);
    end
  endtask

  task automatic test_run_ticks;
    logic [5:0] e, l, ea, la;
    logic [3:0] dv;
    logic [11:0] x;
    int t_new;
    int starts [5] = '{59, 86399, 35999, 71999, 45249};
    for (int r = 0; r < 13; r++) begin
      if (r >= 1 && r <= 5) preset(starts[r-1]);
      else if (r > 5)       preset(int'($urandom_range(0, 86399)));
      for (int n = 0; n < ((r == 0) ? 60 : 3); n++) begin
        t_new = (cur_t + 1) % 86400;
        x = exp_cmd(cur_t, t_new, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, e, l, dv, ea, la);
        checks++;
        if ({e, l, dv} !== {x[5:0], x[11:6], 4'h0}) begin
          errs++;
          $display("FAIL tick_cmd from %h: en=%b load=%b d=%h, required en=%b load=%b d=0",
                   pack(cur_t), e, l, dv, x[5:0], x[11:6]);
        end
        checks++;
        if ({ea, la} !== 12'd0) begin
          errs++;
          $display("FAIL tick_width: en=%b load=%b after command, required 0", ea, la);
        end
        cur_t = t_new;
        checks++;
        if (obs_t !== pack(cur_t)) begin
          errs++;
          $display("FAIL tick_time: time=%h, required %h", obs_t, pack(cur_t));
        end
      end
    end
  endtask

  task automatic test_set_hours;
    logic [5:0] e, l, ea, la;
    logic [3:0] dv;
    logic [11:0] x;
    int nt;
    pulse(1'b0, 1'b1, 1'b0, e, l, dv, ea, la);
    checks++;
    if ({mode, e, l} !== {2'd1, 12'd0}) begin
      errs++;
      $display("FAIL enter_set_h: mode=%0d en=%b load=%b, required mode=1 no command", mode, e, l);
    end
    preset(22 * 3600 + int'($urandom_range(0, 3599)));
    for (int i = 0; i < 25; i++) begin
      nt = hour_inc(cur_t);
      x = exp_cmd(cur_t, nt, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, e, l, dv, ea, la);
      checks++;
      if ({e, l, dv, ea, la} !== {x[5:0], x[11:6], 4'h0, 12'd0}) begin
        errs++;
        $display("FAIL hour_inc_cmd from %h: en=%b load=%b d=%h next=%b/%b, required en=%b load=%b",
                 pack(cur_t), e, l, dv, ea, la, x[5:0], x[11:6]);
      end
      cur_t = nt;
      checks++;
      if (obs_t !== pack(cur_t)) begin
        errs++;
        $display("FAIL hour_inc_time: time=%h, required %h", obs_t, pack(cur_t));
      end
      if (i % 5 == 2) begin
        pulse(1'b1, 1'b0, 1'b0, e, l, dv, ea, la);
        checks++;
        if ({e, l, ea, la, obs_t} !== {24'd0, pack(cur_t)}) begin
          errs++;
          $display("FAIL set_h_tick_frozen: en=%b load=%b time=%h, required no command time=%h",
                   e, l, obs_t, pack(cur_t));
        end
      end
    end
  endtask

  task automatic test_set_minutes;
    logic [5:0] e, l, ea, la;
    logic [3:0] dv;
    logic [11:0] x;
    int nt;
    pulse(1'b0, 1'b1, 1'b0, e, l, dv, ea, la);
    checks++;
    if ({mode, e, l} !== {2'd2, 12'd0}) begin
      errs++;
      $display("FAIL enter_set_m: mode=%0d en=%b load=%b, required mode=2 no command", mode, e, l);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      preset(int'($urandom_range(0, 23)) * 3600 + 59 * 60 + int'($urandom_range(1, 59)));
      else if (i == 3) preset(int'($urandom_range(0, 86399)));
      nt = min_inc(cur_t);
      x = exp_cmd(cur_t, nt, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, e, l, dv, ea, la);
      checks++;
      if ({e, l, dv, ea, la} !== {x[5:0], x[11:6], 4'h0, 12'd0}) begin
        errs++;
        $display("FAIL min_inc_cmd from %h: en=%b load=%b d=%h, required en=%b load=%b",
                 pack(cur_t), e, l, dv, x[5:0], x[11:6]);
      end
      cur_t = nt;
      checks++;
      if (obs_t !== pack(cur_t)) begin
        errs++;
        $display("FAIL min_inc_time: time=%h, required %h", obs_t, pack(cur_t));
      end
    end
    pulse(1'b0, 1'b1, 1'b0, e, l, dv, ea, la);
    cur_t = cur_t - cur_t % 60;
    checks++;
    if ({mode, e, l, dv, ea, la, obs_t} !== {2'd0, 6'd0, 6'b000011, 4'h0, 12'd0, pack(cur_t)}) begin
      errs++;
      $display("FAIL exit_to_run: mode=%0d en=%b load=%b d=%h time=%h, required mode=0 load=000011 time=%h",
               mode, e, l, dv, obs_t, pack(cur_t));
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] e, l, ea, la;
    logic [3:0] dv;
    logic [11:0] x1, x2;
    int t1, t2, nt;
    preset(3599);
    t1 = (cur_t + 1) % 86400;
    t2 = (t1 + 1) % 86400;
    x1 = exp_cmd(cur_t, t1, 1'b1);
    x2 = exp_cmd(t1, t2, 1'b1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk);
    checks++;
    if ({en, load} !== {x1[5:0], x1[11:6]}) begin
      errs++;
      $display("FAIL b2b_first: en=%b load=%b, required en=%b load=%b", en, load, x1[5:0], x1[11:6]);
    end
    @(negedge clk); tick = 1'b0;
    checks++;
    if ({en, load} !== 12'd0) begin
      errs++;
      $display("FAIL b2b_gap: en=%b load=%b, required 0", en, load);
    end
    @(negedge clk);
    checks++;
    if ({en, load} !== {x2[5:0], x2[11:6]}) begin
      errs++;
      $display("FAIL b2b_pending: en=%b load=%b, required en=%b load=%b", en, load, x2[5:0], x2[11:6]);
    end
    @(negedge clk);
    cur_t = t2;
    checks++;
    if (obs_t !== pack(cur_t)) begin
      errs++;
      $display("FAIL b2b_time: time=%h, required %h", obs_t, pack(cur_t));
    end
    // Held btn_inc during the busy cycle must be dropped.
    pulse(1'b0, 1'b1, 1'b0, e, l, dv, ea, la);
    nt = hour_inc(cur_t);
    @(negedge clk); btn_inc = 1'b1;
    @(negedge clk);
    @(negedge clk); btn_inc = 1'b0;
    @(negedge clk);
    cur_t = nt;
    checks++;
    if ({mode, obs_t} !== {2'd1, pack(cur_t)}) begin
      errs++;
      $display("FAIL inc_busy_drop: mode=%0d time=%h, required mode=1 time=%h", mode, obs_t, pack(cur_t));
    end
    pulse(1'b0, 1'b1, 1'b1, e, l, dv, ea, la);
    checks++;
    if ({mode, e, l, ea, la, obs_t} !== {2'd2, 24'd0, pack(cur_t)}) begin
      errs++;
      $display("FAIL mode_inc_same: mode=%0d en=%b load=%b time=%h, required mode=2 no command time=%h",
               mode, e, l, obs_t, pack(cur_t));
    end
    pulse(1'b0, 1'b1, 1'b0, e, l, dv, ea, la);
    cur_t = cur_t - cur_t % 60;
    checks++;
    if ({mode, l, obs_t} !== {2'd0, 6'b000011, pack(cur_t)}) begin
      errs++;
      $display("FAIL b2b_exit: mode=%0d load=%b time=%h, required mode=0 load=000011 time=%h",
               mode, l, obs_t, pack(cur_t));
    end
  endtask

  task automatic test_simultaneous;
    logic [5:0] e, l, ea, la;
    logic [3:0] dv;
    logic [11:0] x;
    int nt;
    preset(int'($urandom_range(0, 86399)));
    nt = (cur_t + 1) % 86400;
    x = exp_cmd(cur_t, nt, 1'b1);
    pulse(1'b1, 1'b1, 1'b0, e, l, dv, ea, la);
    cur_t = nt;
    checks++;
    if ({mode, e, l, obs_t} !== {2'd1, x[5:0], x[11:6], pack(cur_t)}) begin
      errs++;
      $display("FAIL mode_tick_same: mode=%0d en=%b load=%b time=%h, required mode=1 en=%b load=%b time=%h",
               mode, e, l, obs_t, x[5:0], x[11:6], pack(cur_t));
    end
    nt = hour_inc(cur_t);
    x = exp_cmd(cur_t, nt, 1'b0);
    @(negedge clk); btn_inc = 1'b1;
    @(negedge clk); btn_inc = 1'b0;
    checks++;
    if ({en, load} !== {x[5:0], x[11:6]}) begin
      errs++;
      $display("FAIL clr_pre_cmd: en=%b load=%b, required en=%b load=%b", en, load, x[5:0], x[11:6]);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({en, load, d, mode} !== 18'd0) begin
      errs++;
      $display("FAIL clr_async: en=%b load=%b d=%h mode=%0d, required all 0", en, load, d, mode);
    end
    @(negedge clk); clr = 1'b0;
    checks++;
    if (obs_t !== pack(cur_t)) begin
      errs++;
      $display("FAIL clr_abort_time: time=%h, required %h", obs_t, pack(cur_t));
    end
    nt = (cur_t + 1) % 86400;
    x = exp_cmd(cur_t, nt, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, e, l, dv, ea, la);
    cur_t = nt;
    checks++;
    if ({mode, e, l, obs_t} !== {2'd0, x[5:0], x[11:6], pack(cur_t)}) begin
      errs++;
      $display("FAIL clr_recover: mode=%0d en=%b load=%b time=%h, required en=%b load=%b time=%h",
               mode, e, l, obs_t, x[5:0], x[11:6], pack(cur_t));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

  initial begin
    clr = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    pre_en = 1'b0; pre_val = '0;
    #1;
    test_reset();
    test_run_ticks();
    test_set_hours();
    test_set_minutes();
    test_back_to_back();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Sequencing controller for the six cascaded BCD digit counters of the HH:MM:SS digital clock: s0, s1, m0, m1, h0, h1.
- Each digit counter: 4-bit, 0..9 wrap on en, synchronous load with priority over en, its own clear.
- This block reads back all six digit values and drives per-digit en/load plus a shared load-data bus.
- It imposes the 0..5 tens limits and the 00..23 hour wrap, and runs the HH/MM time-setting FSM.

Parameters:
- none (time format fixed at 24 h)

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- tick  in  1  1 Hz strobe, one clk wide
- btn_mode  in  1  debounced single-cycle pulse, advances set mode
- btn_inc  in  1  debounced single-cycle pulse, increments selected field
- q_s0, q_s1, q_m0, q_m1, q_h0, q_h1  in  4 each  current digit values from the counters
- en  out  6  per-digit count enable, bit order {h1,h0,m1,m0,s1,s0}
- load  out  6  per-digit load strobe, same bit order
- d  out  4  shared load value
- mode  out  2  0=RUN, 1=SET_H, 2=SET_M; drives the display blink

Behaviour:
- Reset: clock/reset are a single clk with async active-high clr. While clr is high: mode=RUN, en=0, load=0, d=0, tick_pend=0, busy=0. clr does not clear the digit counters; they have their own clear.
- Outputs registered. A command is en/load asserted for exactly 1 cycle, the cycle after the triggering event is accepted. busy=1 during that cycle.
- Events are evaluated only when busy=0, so Q inputs are always post-update. A tick arriving while busy=1 sets tick_pend (one deep) and is accepted the next cycle.
- FSM transitions:
  - RUN -mode-> SET_H
  - SET_H -mode-> SET_M
  - SET_M -mode-> RUN
  - btn_mode is accepted even when busy=1.
- RUN tick command. Cascade conditions: c0 = s0==9; c1 = c0 & s1>=5; c2 = c1 & m0==9; c3 = c2 & m1>=5.
  - en.s0 = 1.
  - If c0: s1>=5 gives load.s1; otherwise en.s1.
  - If c1: en.m0.
  - If c2: m1>=5 gives load.m1; otherwise en.m1.
  - If c3 and h1==2 and h0>=3: load.h0 and load.h1.
  - Else if c3: en.h0, plus en.h1 if h0==9.
  - d=0 for every load.
- btn_inc in RUN: ignored.
- SET_H, btn_inc (hour +1 mod 24, no carry out):
  - h>=23: load.h0, load.h1, d=0.
  - h0==9: load.h0 with d=0, and en.h1.
  - Otherwise: en.h0.
- SET_M, btn_inc (minute +1 mod 60, no carry into hours):
  - m>=59: load.m0, load.m1, d=0.
  - m0==9: load.m0, en.m1.
  - Otherwise: en.m0.
- Set modes: tick and tick_pend are discarded; the time is frozen.
- Leaving SET_M to RUN: issue load.s0 and load.s1 with d=0, so seconds restart at :00.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode wins and inc is dropped.
  - btn_mode and tick in RUN: the tick command issues, and mode becomes SET_H the same cycle.
  - btn_inc while busy=1: dropped.
- Out-of-range digits (e.g. tens >5): treated as the limit and wrapped to 0; there is no stall.
- clr mid-command: the command is aborted, en/load go 0 immediately, and the FSM returns to RUN.

Test Plan:
- clr, counters at 00:00:00, 60 ticks -> en.s0 on each tick. At 00:00:09 the next tick gives en.s0 plus en.s1. At 00:00:59 it gives en.s0, load.s1, en.m0 with d=0, yielding 00:01:00.
- Preset 23:59:59, one tick -> single cycle with en.s0, load.s1, en.m0, load.m1, load.h0, load.h1 and d=0, yielding 00:00:00.
- mode pulse -> mode=1; 25 inc pulses from h=22 -> 23, 00, 01, ... sequence with no minute change. Ticks during this window -> en stays 0.
- mode twice to SET_M, minute at 59, inc -> m=00 with h unchanged. mode -> RUN plus a load.s0/load.s1 pulse, yielding seconds 00.
- tick asserted in the busy cycle -> tick_pend is set, and a second command issues the following cycle; no tick is lost.
- Stimulus: btn_mode and btn_inc in the same cycle, and clr asserted during a command. Required: only the mode advances on the simultaneous press; on clr, outputs go 0 asynchronously and mode=0.
